multicycle_controller: RTL

//  Moore FSM + condition unit that sequences a multicycle ARM datapath (one shared instr/data memory,
//  IR, ALUOut, data regs). Decodes Instr, steps FETCH..writeback, drives all datapath selects/enables,

---
 rtl/multicycle_controller_pkg.sv | 110 +++++++++++
 rtl/multicycle_controller_if.sv | 29 ++
 rtl/multicycle_controller_cond_unit.sv | 39 +++
 rtl/multicycle_controller.sv | 133 +++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types, select encodings and decode helpers for the multicycle ARM controller.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] SRCA_RN     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;
    localparam logic [1:0] SRCA_ZERO   = 2'b11;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_RDATA   = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] FN_AND = 4'b0000;
    localparam logic [3:0] FN_EOR = 4'b0001;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_ADD = 4'b0100;
    localparam logic [3:0] FN_CMP = 4'b1010;
    localparam logic [3:0] FN_ORR = 4'b1100;
    localparam logic [3:0] FN_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic       valid;
        logic [2:0] alu_ctrl;
        logic       wb;
        logic       zero_a;
        logic       sets_cv;
    } dp_dec_t;

    // Unknown Funct codes come back invalid: no writeback and no flag update.
    function automatic dp_dec_t decode_funct(input logic [3:0] fn);
        dp_dec_t d;
        d = '{valid: 1'b1, alu_ctrl: ALU_ADD, wb: 1'b1, zero_a: 1'b0, sets_cv: 1'b0};
        case (fn)
            FN_ADD:  d.sets_cv = 1'b1;
            FN_SUB:  begin d.alu_ctrl = ALU_SUB; d.sets_cv = 1'b1; end
            FN_CMP:  begin d.alu_ctrl = ALU_SUB; d.sets_cv = 1'b1; d.wb = 1'b0; end
            FN_AND:  d.alu_ctrl = ALU_AND;
            FN_ORR:  d.alu_ctrl = ALU_ORR;
            FN_EOR:  d.alu_ctrl = ALU_EOR;
            FN_MOV:  d.zero_a = 1'b1;
            default: begin d.valid = 1'b0; d.wb = 1'b0; end
        endcase
        return d;
    endfunction

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave the datapath.
interface multicycle_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  RegSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic [3:0]  State;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, State
    );
    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, ResultSrc, State
    );
endinterface

// File: rtl/multicycle_controller_cond_unit.sv
// NZCV flag register plus condition evaluation, latched once per instruction in DECODE.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       cond_latch,
    input  logic       nz_wr,
    input  logic       cv_wr,
    output logic       cond_ex_q
);
    logic [3:0] flags_r;
    logic       cond_ex_q_r;

    // Flag register: NZ and CV halves have independent write enables.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= 4'b0000;
        end else begin
            flags_r[3:2] <= nz_wr ? alu_flags[3:2] : flags_r[3:2];
            flags_r[1:0] <= cv_wr ? alu_flags[1:0] : flags_r[1:0];
        end
    end

    // Condition latch so writeback sees flags from before this instruction executed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_ex_q_r <= 1'b0;
        end else if (cond_latch) begin
            cond_ex_q_r <= cond_eval(cond, flags_r);
        end else begin
            cond_ex_q_r <= cond_ex_q_r;
        end
    end

    assign cond_ex_q = cond_ex_q_r;
endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for a multicycle ARM datapath: decode, state stepping, select and enable generation.
module multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    state_t     state_r;
    logic [3:0] cond_s, rd_s;
    logic [1:0] op_s;
    logic [5:0] funct_s;
    logic       mem_rdy_s, cond_ex_q_s, rd_pc_s, nz_wr_s, cv_wr_s, wb_s;
    logic       pc_wr_s, reg_wr_s, mem_wr_s, ir_wr_s, adr_src_s;
    logic [1:0] src_a_s, src_b_s, res_src_s;
    logic [2:0] alu_ctl_s;
    logic       rn_unused_s;
    dp_dec_t    dp_dec_s;

    assign cond_s      = bus.Instr[19:16];
    assign op_s        = bus.Instr[15:14];
    assign funct_s     = bus.Instr[13:8];
    assign rd_s        = bus.Instr[3:0];
    assign rn_unused_s = ^bus.Instr[7:4];
    assign rd_pc_s     = (rd_s == 4'hF);
    assign mem_rdy_s   = MEM_WAIT_EN ? bus.MemReady : 1'b1;
    assign dp_dec_s    = decode_funct(funct_s[4:1]);
    assign nz_wr_s     = ((state_r == EXECR) || (state_r == EXECI)) & cond_ex_q_s & funct_s[0] & dp_dec_s.valid;
    assign cv_wr_s     = nz_wr_s & dp_dec_s.sets_cv;

    cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond_s),
        .alu_flags  (bus.ALUFlags),
        .cond_latch (state_r == DECODE),
        .nz_wr      (nz_wr_s),
        .cv_wr      (cv_wr_s),
        .cond_ex_q  (cond_ex_q_s)
    );

    // Instruction sequencing state machine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
        end else begin
            case (state_r)
                FETCH:    state_r <= mem_rdy_s ? DECODE : FETCH;
                DECODE: begin
                    case (op_s)
                        OP_MEM:  state_r <= MEMADR;
                        OP_DP:   state_r <= funct_s[5] ? EXECI : EXECR;
                        OP_BR:   state_r <= BRANCH;
                        default: state_r <= FETCH;
                    endcase
                end
                MEMADR:   state_r <= funct_s[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  state_r <= mem_rdy_s ? MEMWB : MEMREAD;
                MEMWRITE: state_r <= mem_rdy_s ? FETCH : MEMWRITE;
                EXECR:    state_r <= ALUWB;
                EXECI:    state_r <= ALUWB;
                default:  state_r <= FETCH;
            endcase
        end
    end

    // Per-state datapath selects and raw enables; the PC-increment path is the idle default.
    always_comb begin
        pc_wr_s   = 1'b0;
        reg_wr_s  = 1'b0;
        mem_wr_s  = 1'b0;
        ir_wr_s   = 1'b0;
        wb_s      = 1'b0;
        adr_src_s = 1'b0;
        src_a_s   = SRCA_PC;
        src_b_s   = SRCB_FOUR;
        alu_ctl_s = ALU_ADD;
        res_src_s = RES_ALURES;
        case (state_r)
            FETCH: begin
                ir_wr_s = mem_rdy_s;
                pc_wr_s = mem_rdy_s;
            end
            MEMADR: begin
                src_a_s   = SRCA_RN;
                src_b_s   = SRCB_IMM;
                alu_ctl_s = funct_s[3] ? ALU_ADD : ALU_SUB;
            end
            MEMREAD:  adr_src_s = 1'b1;
            MEMWB: begin
                res_src_s = RES_RDATA;
                wb_s      = cond_ex_q_s;
            end
            MEMWRITE: begin
                adr_src_s = 1'b1;
                mem_wr_s  = cond_ex_q_s;
            end
            EXECR, EXECI: begin
                src_a_s   = dp_dec_s.zero_a ? SRCA_ZERO : SRCA_RN;
                src_b_s   = (state_r == EXECI) ? SRCB_IMM : SRCB_REG;
                alu_ctl_s = dp_dec_s.alu_ctrl;
            end
            ALUWB: begin
                res_src_s = RES_ALUOUT;
                wb_s      = cond_ex_q_s & dp_dec_s.wb;
            end
            BRANCH: begin
                src_a_s = SRCA_ALUOUT;
                src_b_s = SRCB_IMM;
                pc_wr_s = cond_ex_q_s;
            end
            default: pc_wr_s = 1'b0;
        endcase
        // A writeback targeting R15 becomes a PC load instead of a register write.
        pc_wr_s  = pc_wr_s | (wb_s & rd_pc_s);
        reg_wr_s = wb_s & ~rd_pc_s;
    end

    assign bus.PCWrite    = pc_wr_s & reset;
    assign bus.RegWrite   = reg_wr_s & reset;
    assign bus.MemWrite   = mem_wr_s & reset;
    assign bus.IRWrite    = ir_wr_s & reset;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.ALUSrcA    = src_a_s;
    assign bus.ALUSrcB    = src_b_s;
    assign bus.ALUControl = alu_ctl_s;
    assign bus.ResultSrc  = res_src_s;
    assign bus.RegSrc     = {op_s == OP_MEM, op_s == OP_BR};
    assign bus.ImmSrc     = op_s;
    assign bus.State      = state_r;
endmodule
